// File: rtl/branch_resolve_unit.sv
// Branch resolution in EX with one registered result stage, misprediction detection and a
// 2-bit saturating-counter BHT. Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic [XLEN-1:0] res_redirect_pc,
    output logic            res_illegal
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
`endif
);

    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    logic [1:0]      bht_r [BHT_ENTRIES];
    logic [IDX-1:0]  upd_idx_r;
    logic            accept_s;
    logic            taken_s;
    logic            legal_s;
    logic [XLEN-1:0] seq_pc_s;
    logic            unused_if_pc_s;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

    assign accept_s       = ex_valid & ~ex_flush;
    assign seq_pc_s       = ex_pc + PC_STEP;
    assign if_pred_taken  = bht_r[if_pc[IDX+1:2]][1];
    assign unused_if_pc_s = ^if_pc;

    // Branch condition evaluation; the two reserved encodings are flagged illegal and never taken.
    always_comb begin
        taken_s = 1'b0;
        legal_s = 1'b1;
        case (ex_funct3)
            3'b000:  taken_s = (ex_rs1 == ex_rs2);
            3'b001:  taken_s = (ex_rs1 != ex_rs2);
            3'b100:  taken_s = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  taken_s = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  taken_s = (ex_rs1 <  ex_rs2);
            3'b111:  taken_s = (ex_rs1 >= ex_rs2);
            default: begin
                taken_s = 1'b0;
                legal_s = 1'b0;
            end
        endcase
    end

    // Result stage: one pulse per accepted branch; redirect PC holds when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_mispredict  <= 1'b0;
            res_illegal     <= 1'b0;
            res_redirect_pc <= {XLEN{1'b0}};
            upd_idx_r       <= {IDX{1'b0}};
        end else begin
            res_valid <= accept_s;
            if (accept_s) begin
                res_taken       <= taken_s;
                res_mispredict  <= taken_s ^ ex_pred_taken;
                res_illegal     <= ~legal_s;
                res_redirect_pc <= taken_s ? ex_target : seq_pc_s;
                upd_idx_r       <= ex_pc[IDX+1:2];
            end else begin
                res_taken      <= 1'b0;
                res_mispredict <= 1'b0;
                res_illegal    <= 1'b0;
            end
        end
    end

    // BHT training from the registered result; reset wins over a pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (res_valid && !res_illegal) begin
            bht_r[upd_idx_r] <= sat_update(bht_r[upd_idx_r], res_taken);
        end else begin
            bht_r[upd_idx_r] <= bht_r[upd_idx_r];
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Performance counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches    <= {CNT_W{1'b0}};
            perf_mispredicts <= {CNT_W{1'b0}};
        end else begin
            if (res_valid && !res_illegal) begin
                perf_branches <= perf_branches + CNT_W'(1'b1);
            end else begin
                perf_branches <= perf_branches;
            end
            if (res_valid && res_mispredict) begin
                perf_mispredicts <= perf_mispredicts + CNT_W'(1'b1);
            end else begin
                perf_mispredicts <= perf_mispredicts;
            end
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w_s;
    assign unused_cnt_w_s = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the combinational branch comparator. Resolves conditional branches in EX with one registered output stage, detects mispredictions against the front-end guess, and produces the redirect PC. Holds a direct-mapped table of 2-bit saturating counters (BHT) that IF reads for prediction and resolved branches train.

Parameters:
XLEN, 32, operand and PC width (>= 8)
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >= 2
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
if_pc  in  XLEN  fetch PC for the prediction lookup
if_pred_taken  out  1  combinational: MSB of BHT[if_pc[IDX+1:2]], IDX = log2(BHT_ENTRIES)
ex_valid  in  1  conditional branch present in EX this cycle
ex_flush  in  1  kill the EX instruction; overrides ex_valid
ex_funct3  in  3  branch type (instruction[14:12])
ex_rs1  in  XLEN  operand 1
ex_rs2  in  XLEN  operand 2
ex_pc  in  XLEN  PC of the branch
ex_target  in  XLEN  computed taken target
ex_pred_taken  in  1  prediction carried down the pipe with this branch
res_valid  out  1  registered result valid
res_taken  out  1  branch outcome
res_mispredict  out  1  outcome != carried prediction
res_redirect_pc  out  XLEN  ex_target if taken, else ex_pc + 4
res_illegal  out  1  funct3 is not a branch encoding
perf_branches  out  CNT_W  resolved branch count (BRU_PERF_CNT_EN only)
perf_mispredicts  out  CNT_W  mispredict count (BRU_PERF_CNT_EN only)

Behaviour:
- Compare on ex_funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU, XLEN-wide. 010/011 are illegal.
- Latency 1. An accepted branch (ex_valid & ~ex_flush) at edge N drives res_* valid during cycle N+1. res_valid is a single-cycle pulse per accepted branch. Back-to-back branches are accepted every cycle with no stall.
- If not accepted: res_valid = 0 next cycle and no BHT update. res_taken, res_mispredict and res_illegal are forced to 0. res_redirect_pc holds its last value.
- res_mispredict = res_taken XOR registered ex_pred_taken.
- res_redirect_pc: ex_pc + 4 wraps modulo 2^XLEN (e.g. all-ones minus 3 -> 0).
- Illegal funct3: res_taken = 0, res_illegal = 1, res_redirect_pc = ex_pc + 4, res_mispredict = ex_pred_taken. No BHT update.
- BHT index = ex_pc[IDX+1:2].
- BHT update happens at the edge ending the res_valid cycle (legal branches only):
  - taken: counter saturates up at 11.
  - not taken: counter saturates down at 00.
- BHT read/write to the same index in the same cycle: if_pred_taken shows the pre-update value. No bypass.
- Reset:
  - Every BHT entry is set to 01 (weakly not-taken).
  - res_valid, res_taken, res_mispredict and res_illegal go to 0; res_redirect_pc goes to 0.
  - Perf counters go to 0.
  - rst mid-operation discards the in-flight result. rst has priority over any update in the same cycle.
- During rst, if_pred_taken reads the pre-reset table. From the first cycle after rst deasserts it reads 0 for all entries.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - perf_branches increments on each res_valid with res_illegal = 0.
  - perf_mispredicts increments on each res_valid with res_mispredict = 1, illegal branches included.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: both perf ports are absent from the port list and no counter logic exists. All other behaviour is identical.

Test Plan:
- Reset, then sweep if_pc over all BHT_ENTRIES indices -> if_pred_taken = 0 for every index. One cycle after ex_valid=1, funct3=000, rs1=rs2=5, pred=0 -> res_valid=1, res_taken=1, res_mispredict=1, res_redirect_pc=ex_target.
- Signed/unsigned split: rs1=0xFFFFFFFF, rs2=1; BLT -> taken; BLTU -> not taken; BGE -> not taken; BGEU -> taken. res_redirect_pc = pc+4 on the not-taken cases.
- Training: same pc=0x100, taken three times -> counter goes 01 -> 10 -> 11 -> 11; if_pred_taken at if_pc=0x100 goes 0 -> 1 -> 1 -> 1. Then two not-taken -> 10 then 01, prediction back to 0.
- ex_flush=1 with ex_valid=1 -> res_valid=0, BHT unchanged, perf counters unchanged. funct3=010 with pred=1 -> res_illegal=1, res_taken=0, res_mispredict=1, no BHT update, perf_branches unchanged, perf_mispredicts +1.
- Wrap: ex_pc=0xFFFFFFFC, not taken -> res_redirect_pc=0x00000000. Back-to-back branches on 3 consecutive cycles -> 3 consecutive res_valid pulses with matching results.
- rst asserted in the cycle res_valid would be 1 -> res_valid=0 and entry stays 01 after reset. Perf counters: CNT_W=4 with 17 branches -> perf_branches=1.
